// File: rtl/fp_norm_round_seq.sv
// rtl/fp_norm_round_seq.sv - iterative normaliser/rounder for the expanded fp result bus
// Optional flags port and flag logic: define FPNORM_FLAGS_EN.
module fp_norm_round_seq #(
    parameter int FPWID      = 64,
    parameter int SHIFT_STEP = 8,
    localparam int EMSB = (FPWID == 128) ? 14 : (FPWID == 64) ? 10 : (FPWID == 32) ? 7 :
                          (FPWID == 16) ? 4 : 10,
    localparam int MSB  = FPWID - 1,
    localparam int FMSB = FPWID - EMSB - 3,
    localparam int FX   = 2 * FMSB + 3,
    localparam int EX   = FX + EMSB + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [2:0]    rm,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [EX:0]   i,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [MSB:0]  o
`ifdef FPNORM_FLAGS_EN
    ,
    output logic [3:0]    flags
`endif
);

    localparam int EW = EMSB + 2;
    localparam logic [EW-1:0] E_ONE   = EW'(1);
    localparam logic [EW-1:0] E_ONES  = {1'b0, {(EMSB+1){1'b1}}};
    localparam logic [EW-1:0] E_STEP  = EW'(SHIFT_STEP);
    localparam logic [EMSB:0] EF_ONES = '1;
    localparam logic [EMSB:0] EF_MAX  = {{EMSB{1'b1}}, 1'b0};
    localparam logic [FMSB:0] F_ONES  = '1;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t          state, state_n;
    logic            sign_q, sign_n;
    logic [EW-1:0]   exp_q, exp_n;
    logic [FX:0]     mo_q, mo_n;
    logic            sticky_q, sticky_n;
    logic [2:0]      rm_q, rm_n;
    logic            special_q, special_n;
    logic            zero_q, zero_n;
    logic [MSB:0]    o_n;

    logic [EW-1:0]   lz, shamt;
    logic [FMSB:0]   frac;
    logic            g, r, s, inc, ovf;
    logic [FMSB+2:0] rounded;
    logic [EW-1:0]   efield;
    logic [MSB:0]    res;

    // Distance from the hidden-bit position to the leading one.
    function automatic logic [EW-1:0] lzc_f(input logic [FX-1:0] m);
        logic [EW-1:0] cnt;
        cnt = EW'(FX);
        for (int k = 0; k < FX; k++)
            if (m[k]) cnt = EW'(FX - 1 - k);
        return cnt;
    endfunction

    assign i_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    always_comb begin
        lz    = lzc_f(mo_q[FX-1:0]);
        shamt = lz;
        if (E_STEP < shamt) shamt = E_STEP;
        if ((exp_q - E_ONE) < shamt) shamt = exp_q - E_ONE;
    end

    always_comb begin
        frac    = mo_q[FX-2 -: FMSB+1];
        g       = mo_q[FX-FMSB-3];
        r       = mo_q[FX-FMSB-4];
        s       = (|mo_q[FX-FMSB-5:0]) | sticky_q;
        case (rm_q)
            3'd1:    inc = 1'b0;
            3'd2:    inc = !sign_q & (g | r | s);
            3'd3:    inc = sign_q & (g | r | s);
            3'd4:    inc = g;
            default: inc = g & (r | s | frac[0]);
        endcase
        rounded = {2'b00, mo_q[FX-1], frac} + (FMSB+3)'(inc);
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (rounded[FMSB+2])
            efield = exp_q + E_ONE;
        else if (rounded[FMSB+1])
            efield = mo_q[FX-1] ? exp_q : E_ONE;
        else
            efield = '0;
        ovf = (efield >= E_ONES);
        if (special_q)
            res = {sign_q, EF_ONES, frac};
        else if (zero_q)
            res = {sign_q, {(MSB){1'b0}}};
        else if (ovf) begin
            case (rm_q)
                3'd1:    res = {sign_q, EF_MAX, F_ONES};
                3'd2:    res = sign_q ? {sign_q, EF_MAX, F_ONES} : {sign_q, EF_ONES, {(FMSB+1){1'b0}}};
                3'd3:    res = sign_q ? {sign_q, EF_ONES, {(FMSB+1){1'b0}}} : {sign_q, EF_MAX, F_ONES};
                default: res = {sign_q, EF_ONES, {(FMSB+1){1'b0}}};
            endcase
        end else
            res = {sign_q, efield[EMSB:0], rounded[FMSB:0]};
    end

`ifdef FPNORM_FLAGS_EN
    logic [3:0] flags_n;
    logic       inexact;
    always_comb begin
        inexact    = !special_q & !zero_q & (g | r | s);
        flags_n    = flags;
        if (state == S_ROUND) begin
            flags_n[3] = inexact;
            flags_n[2] = !special_q & !zero_q & !ovf & (efield == '0) & inexact;
            flags_n[1] = !special_q & !zero_q & ovf;
            flags_n[0] = special_q & frac[FMSB];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags <= '0;
        else if (ce)
            flags <= flags_n;
    end
`endif

    always_comb begin
        state_n   = state;
        sign_n    = sign_q;
        exp_n     = exp_q;
        mo_n      = mo_q;
        sticky_n  = sticky_q;
        rm_n      = rm_q;
        special_n = special_q;
        zero_n    = zero_q;
        o_n       = o;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    sign_n    = i[EX];
                    exp_n     = {1'b0, i[EX-1 -: EMSB+1]};
                    mo_n      = i[FX:0];
                    rm_n      = rm;
                    sticky_n  = 1'b0;
                    special_n = 1'b0;
                    zero_n    = 1'b0;
                    state_n   = S_NORM;
                end
            end
            S_NORM: begin
                if (exp_q == E_ONES) begin
                    special_n = 1'b1;
                    state_n   = S_ROUND;
                end else if (mo_q == '0) begin
                    zero_n  = 1'b1;
                    state_n = S_ROUND;
                end else if (mo_q[FX]) begin
                    mo_n     = mo_q >> 1;
                    sticky_n = sticky_q | mo_q[0];
                    exp_n    = exp_q + E_ONE;
                    state_n  = S_ROUND;
                end else if (mo_q[FX-1] || exp_q <= E_ONE) begin
                    state_n = S_ROUND;
                end else begin
                    mo_n  = mo_q << shamt;
                    exp_n = exp_q - shamt;
                end
            end
            S_ROUND: begin
                o_n     = res;
                state_n = S_DONE;
            end
            default: begin
                if (o_ready) state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mo_q      <= '0;
            sticky_q  <= 1'b0;
            rm_q      <= '0;
            special_q <= 1'b0;
            zero_q    <= 1'b0;
            o         <= '0;
        end else if (ce) begin
            state     <= state_n;
            sign_q    <= sign_n;
            exp_q     <= exp_n;
            mo_q      <= mo_n;
            sticky_q  <= sticky_n;
            rm_q      <= rm_n;
            special_q <= special_n;
            zero_q    <= zero_n;
            o         <= o_n;
        end
    end

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// tb/tb_fp_norm_round_seq.sv - scoreboard bench for fp_norm_round_seq at FPWID=64
module tb_fp_norm_round_seq;

    localparam int FX = 105;
    localparam int EX = 117;

    logic          clk = 1'b0;
    logic          rst, ce, i_valid, o_ready, i_ready, o_valid;
    logic [2:0]    rm;
    logic [EX:0]   i;
    logic [63:0]   o;
`ifdef FPNORM_FLAGS_EN
    logic [3:0]    flags;
`endif

    int            checks = 0;
    int            errors = 0;
    string         cur_tag = "none";
    logic [67:0]   sb_q[$];

    fp_norm_round_seq #(.FPWID(64), .SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rm(rm),
        .i_valid(i_valid), .i_ready(i_ready), .i(i),
        .o_valid(o_valid), .o_ready(o_ready), .o(o)
`ifdef FPNORM_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [FX:0] bit_at(input int k);
        logic [FX:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Results are compared in the cycle before the output handshake edge.
    always @(negedge clk) begin
        if (!rst && ce && o_valid && o_ready) begin
            if (sb_q.size() == 0)
                check({cur_tag, "_spurious_o_valid"}, {127'b0, o_valid}, 128'd0);
            else begin
                logic [67:0] e;
                e = sb_q.pop_front();
                check({cur_tag, "_o"}, o, e[63:0]);
`ifdef FPNORM_FLAGS_EN
                check({cur_tag, "_flags"}, flags, e[67:64]);
`endif
            end
        end
    end

    task automatic run_op(input string tag, input logic s, input logic [10:0] e, input logic [FX:0] m,
                          input logic [2:0] r, input logic [63:0] want_o, input logic [3:0] want_f,
                          input int want_lat, input int hold, input int ce_gap);
        int lat;
        int guard;
        cur_tag = tag;
        o_ready = (hold == 0);
        guard = 0;
        while (!i_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_i_ready"}, i_ready, 1);
        i = {s, e, m};
        rm = r;
        i_valid = 1'b1;
        sb_q.push_back({want_f, want_o});
        @(posedge clk); #1;
        i_valid = 1'b0;
        i = '0;
        rm = ~r;
        if (ce_gap > 0) begin
            ce = 1'b0;
            repeat (ce_gap) begin
                @(posedge clk); #1;
                check({tag, "_ce_frozen"}, {o_valid, i_ready}, 2'b00);
            end
            ce = 1'b1;
        end
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, want_lat);
        repeat (hold) begin
            check({tag, "_hold_o"}, o, want_o);
            check({tag, "_hold_ready"}, {o_valid, i_ready}, 2'b10);
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        guard = 0;
        while (o_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_retire"}, o_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FX:0] m;
        int          seen;
        rst = 1'b1; ce = 1'b1; i_valid = 1'b0; o_ready = 1'b1; rm = '0; i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_i_ready", i_ready, 1);
        check("reset_o_valid", o_valid, 0);
        check("reset_o", o, 0);
`ifdef FPNORM_FLAGS_EN
        check("reset_flags", flags, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("carry",   0, 11'h3FF, bit_at(FX),      3'd0, 64'h4000000000000000, 4'b0000, 2, 0, 0);
        run_op("lz19",    0, 11'h3FF, bit_at(FX-20),   3'd0, 64'h3EC0000000000000, 4'b0000, 5, 0, 0);
        m = bit_at(104) | bit_at(52) | bit_at(51);
        run_op("rne_tie", 1, 11'h3FF, m, 3'd0, 64'hBFF0000000000002, 4'b1000, 2, 0, 0);
        run_op("rtz",     1, 11'h3FF, m, 3'd1, 64'hBFF0000000000001, 4'b1000, 2, 0, 0);
        run_op("rdn",     1, 11'h3FF, m, 3'd3, 64'hBFF0000000000002, 4'b1000, 2, 0, 0);
        run_op("rup",     1, 11'h3FF, m, 3'd2, 64'hBFF0000000000001, 4'b1000, 2, 0, 0);
        run_op("rmm",     1, 11'h3FF, m, 3'd4, 64'hBFF0000000000002, 4'b1000, 2, 0, 0);
        m = bit_at(104) | bit_at(51);
        run_op("rne_even", 0, 11'h3FF, m, 3'd6, 64'h3FF0000000000000, 4'b1000, 2, 0, 0);
        m = bit_at(FX) | bit_at(52) | bit_at(0);
        run_op("sticky",  0, 11'h3FF, m, 3'd0, 64'h4000000000000001, 4'b1000, 2, 0, 0);
        run_op("ovf_rne", 0, 11'h7FE, bit_at(FX), 3'd0, 64'h7FF0000000000000, 4'b0010, 2, 0, 0);
        run_op("ovf_rtz", 0, 11'h7FE, bit_at(FX), 3'd1, 64'h7FEFFFFFFFFFFFFF, 4'b0010, 2, 0, 0);
        run_op("ovf_rup_neg", 1, 11'h7FE, bit_at(FX), 3'd2, 64'hFFEFFFFFFFFFFFFF, 4'b0010, 2, 0, 0);
        run_op("ovf_rdn_pos", 0, 11'h7FE, bit_at(FX), 3'd3, 64'h7FEFFFFFFFFFFFFF, 4'b0010, 2, 0, 0);
        run_op("denorm",  0, 11'h001, bit_at(FX-3), 3'd0, 64'h0004000000000000, 4'b0000, 2, 0, 0);
        m = bit_at(FX-3) | bit_at(10);
        run_op("underflow", 0, 11'h001, m, 3'd0, 64'h0004000000000000, 4'b1100, 2, 0, 0);
        m = '0;
        m[103:52] = '1;
        m[51] = 1'b1;
        run_op("denorm_carry", 0, 11'h001, m, 3'd0, 64'h0010000000000000, 4'b1000, 2, 0, 0);
        run_op("exp_limited", 0, 11'h005, bit_at(FX-20), 3'd0, 64'h0000002000000000, 4'b0000, 3, 0, 0);
        run_op("qnan",    0, 11'h7FF, bit_at(FX-2), 3'd0, 64'h7FF8000000000000, 4'b0001, 2, 0, 0);
        run_op("inf",     1, 11'h7FF, '0, 3'd0, 64'hFFF0000000000000, 4'b0000, 2, 0, 0);
        run_op("zero",    1, 11'h123, '0, 3'd2, 64'h8000000000000000, 4'b0000, 2, 0, 0);
        run_op("hold",    0, 11'h3FF, bit_at(FX), 3'd0, 64'h4000000000000000, 4'b0000, 2, 10, 0);
        run_op("ce_gap",  0, 11'h3FF, bit_at(FX-20), 3'd0, 64'h3EC0000000000000, 4'b0000, 5, 0, 4);

        cur_tag = "rst_norm";
        i = {1'b0, 11'h3FF, bit_at(FX-20)};
        rm = 3'd0;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("rst_norm_busy", {o_valid, i_ready}, 2'b00);
        rst = 1'b1;
        #1;
        check("rst_norm_async", {o_valid, i_ready}, 2'b01);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_norm_i_ready", i_ready, 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check("rst_norm_no_o_valid", seen, 0);

        run_op("after_rst", 0, 11'h3FF, bit_at(FX), 3'd0, 64'h4000000000000000, 4'b0000, 2, 0, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
